// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Multi-cycle MEM-stage controller for an external 16-bit asynchronous SRAM.
//   One load or store is accepted at a time. Each 32-bit word moves as two
//   16-bit halves, low half first. The pipeline freezes on (request && !ready).
//
//   Handshake: a request (mem_r_en / mem_w_en) is sampled in IDLE; address,
//   data and operation are latched there and later input changes are ignored.
//   ready is low from the sampling cycle until the single DONE cycle, in which
//   the pipeline advances. A request still high in the following IDLE cycle
//   starts a new access.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_r_en, mem_w_en  load / store request (both high means store)
//   address, wr_data    byte address and store data
//   rd_data             registered load result, valid from the DONE cycle
//   ready               combinational: idle with no request, or DONE
//   sram_*              registered SRAM pin controls; sram_dq_in is SRAM data
//   dbg_state           current FSM state (IDLE=0, LO=1, HI=2, DONE=3)
module sram_mem_controller #(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        phase_cnt;
  logic [ADDR_W-2:0] word_idx;
  logic [31:0]       wr_buf;
  logic              is_write;

  logic [ADDR_W-2:0] next_idx;
  logic              req;
  logic              last_cycle;
  logic              pre_last;

  // Word index wraps modulo 2^(ADDR_W-1); no range check.
  assign next_idx   = (ADDR_W-1)'((address - BASE_ADDR) >> 2);
  assign req        = mem_r_en || mem_w_en;
  assign last_cycle = (phase_cnt == LAST_CNT);
  // Next cycle is the last of the phase: release WE for the hold cycle.
  assign pre_last   = (phase_cnt == LAST_CNT - 4'd1);

  assign ready     = ((state == IDLE) && !req) || (state == DONE);
  assign dbg_state = state;

  // Strobes are set up one edge ahead so every SRAM pin comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= 4'd0;
      word_idx    <= '0;
      wr_buf      <= 32'd0;
      is_write    <= 1'b0;
      rd_data     <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            word_idx    <= next_idx;
            wr_buf      <= wr_data;
            is_write    <= mem_w_en;
            phase_cnt   <= 4'd0;
            state       <= LO;
            sram_addr   <= {next_idx, 1'b0};
            sram_dq_out <= wr_data[15:0];
            sram_dq_oe  <= mem_w_en;
            // WAIT_CYCLES >= 1, so the first phase cycle is never the hold cycle.
            sram_we_n   <= !mem_w_en;
            sram_oe_n   <= mem_w_en;
          end
        end
        LO: begin
          if (last_cycle) begin
            if (!is_write) rd_data[15:0] <= sram_dq_in;
            state       <= HI;
            phase_cnt   <= 4'd0;
            sram_addr   <= {word_idx, 1'b1};
            sram_dq_out <= wr_buf[31:16];
            sram_we_n   <= !is_write;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
            if (pre_last) sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (last_cycle) begin
            if (!is_write) rd_data[31:16] <= sram_dq_in;
            state      <= DONE;
            phase_cnt  <= 4'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
            if (pre_last) sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller
//   Directed bench for sram_mem_controller (default parameters) with a small
//   clocked SRAM model. Inputs change on the falling edge; outputs are sampled
//   1 time unit after the rising edge.
module tb_sram_mem_controller;

  logic        clk;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Results of the last access
  int busy;
  int we_lo;
  int we_hi;
  int oe_cnt;
  int dq_cnt;
  logic done;

  logic [15:0] mem [0:63];

  sram_mem_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  assign sram_dq_in = (!sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] = sram_dq_out;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge while the DUT is idle. Holds the request
  // until the DONE cycle (or drops it after drop_at busy samples), returns in
  // the DONE cycle with the request released.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at);
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wr_data  = d;
    busy = 1; we_lo = 0; we_hi = 0; oe_cnt = 0; dq_cnt = 0; done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (!sram_we_n) begin
        if (sram_addr[0]) we_hi++;
        else we_lo++;
      end
      if (!sram_oe_n) oe_cnt++;
      if (sram_dq_oe) dq_cnt++;
      if (k == drop_at) begin
        @(negedge clk);
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
      end
    end
    check("access_done_within_budget", {31'd0, done}, 32'd1);
    @(negedge clk);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst_n    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'd0;
    wr_data  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    check("reset_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("reset_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 1024 <- DEADBEEF
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0);
    check("wr0_busy", busy, 32'd5);
    check("wr0_we_lo", we_lo, 32'd1);
    check("wr0_we_hi", we_hi, 32'd1);
    check("wr0_dq_oe_cycles", dq_cnt, 32'd4);
    check("wr0_ready_done", {31'd0, ready}, 32'd1);
    check("wr0_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("wr0_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    @(negedge clk); #1;
    check("wr0_idle_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // Read 1024
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 0);
    check("rd0_busy", busy, 32'd5);
    check("rd0_data", rd_data, 32'hDEADBEEF);
    check("rd0_oe_cycles", oe_cnt, 32'd4);
    check("rd0_dq_oe_cycles", dq_cnt, 32'd0);
    check("rd0_we_cycles", we_lo + we_hi, 32'd0);
    @(negedge clk);

    // Write 1028 <- 12345678, read back, re-read 1024
    do_access(1'b0, 1'b1, 32'd1028, 32'h12345678, 0);
    check("wr1_mem2", {16'd0, mem[2]}, 32'h00005678);
    check("wr1_mem3", {16'd0, mem[3]}, 32'h00001234);
    check("wr1_rd_data_held", rd_data, 32'hDEADBEEF);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 0);
    check("rd1_data", rd_data, 32'h12345678);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 0);
    check("rd0_again_data", rd_data, 32'hDEADBEEF);
    @(negedge clk);

    // Both strobes: behaves as write to 1032
    do_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 0);
    check("both_mem4", {16'd0, mem[4]}, 32'h00005A5A);
    check("both_mem5", {16'd0, mem[5]}, 32'h0000A5A5);
    check("both_rd_data_held", rd_data, 32'hDEADBEEF);
    check("both_oe_cycles", oe_cnt, 32'd0);
    @(negedge clk);

    // Request dropped in the second LO cycle
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 2);
    check("drop_busy", busy, 32'd5);
    check("drop_data", rd_data, 32'h12345678);
    @(negedge clk); #1;
    check("drop_idle_ready", {31'd0, ready}, 32'd1);
    check("drop_idle_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);

    // Reset during the first HI cycle of a write
    mem_w_en = 1'b1;
    address  = 32'd1036;
    wr_data  = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_we_n_low", {31'd0, sram_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    mem_w_en = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 0);
    check("post_rst_busy", busy, 32'd5);
    check("post_rst_data", rd_data, 32'h12345678);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
